ex_stage_pipe: RTL and testbench

Parametrised execute-to-memory pipeline register for the RV64I core, successor to the fixed single-entry execute stage register. Adds valid/ready handshakes on both sides and a configurable-depth RAW hazard scoreboard covering older in-flight writers. Adds explicit flush, control-flow redirect with wrong-path squash, and a saturating stall counter for performance monitoring. Sits between decode/ALU and the memory/writeback stage.

---
 rtl/ex_stage_pipe.sv | 112 +++++++++++
 tb/tb_ex_stage_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute-to-memory pipeline register with valid/ready handshakes, RAW scoreboard,
// flush, control-flow redirect squash and a saturating stall counter.
module ex_stage_pipe #(
   parameter int XLEN = 64,
   parameter int REG_ADDR_W = 5,
   parameter int PAYLOAD_W = 192,
   parameter int TRACK_DEPTH = 3,
   parameter int CNT_W = 16,
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_inst,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [PAYLOAD_W-1:0]  in_payload,
   input  logic [REG_ADDR_W-1:0] in_rs1_addr,
   input  logic [REG_ADDR_W-1:0] in_rs2_addr,
   input  logic                  in_rs1_used,
   input  logic                  in_rs2_used,
   input  logic [REG_ADDR_W-1:0] in_rd_addr,
   input  logic                  in_rd_we,
   input  logic                  mem_ready,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_inst,
   output logic [XLEN-1:0]       out_pc,
   output logic [PAYLOAD_W-1:0]  out_payload,
   output logic [REG_ADDR_W-1:0] out_rd_addr,
   output logic                  out_rd_we,
   output logic                  redirect,
   output logic                  stall,
   output logic [CNT_W-1:0]      stall_count
);
   localparam logic [6:0] OP_LOAD = 7'b0000011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic [TRACK_DEPTH-1:0] hit;
   logic raw_hazard;
   logic load_hazard;
   logic hold;
   logic accept;

   function automatic logic dep(input logic v, input logic [REG_ADDR_W-1:0] rd,
                                input logic [REG_ADDR_W-1:0] rs1, input logic [REG_ADDR_W-1:0] rs2,
                                input logic u1, input logic u2);
      return v && (rd != '0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
   endfunction

   assign hit[0] = dep(out_valid & out_rd_we, out_rd_addr, in_rs1_addr, in_rs2_addr, in_rs1_used, in_rs2_used);

   generate
      if (TRACK_DEPTH > 1) begin : g_hist
         logic [TRACK_DEPTH-1:1] hv;
         logic [REG_ADDR_W-1:0] hrd [1:TRACK_DEPTH-1];
         // slot 1 records the writer leaving the output register; older slots age every cycle
         always_ff @(posedge clk) begin
            if (rst || flush) begin
               hv <= '0;
            end else begin
               hv[1] <= out_valid & out_ready & out_rd_we;
               for (int k = 2; k < TRACK_DEPTH; k++) hv[k] <= hv[k-1];
            end
            hrd[1] <= out_rd_addr;
            for (int k = 2; k < TRACK_DEPTH; k++) hrd[k] <= hrd[k-1];
         end
         for (genvar k = 1; k < TRACK_DEPTH; k++) begin : g_hit
            assign hit[k] = dep(hv[k], hrd[k], in_rs1_addr, in_rs2_addr, in_rs1_used, in_rs2_used);
         end
      end
   endgenerate

   assign raw_hazard = in_valid & (|hit);
   assign load_hazard = in_valid & (in_inst[6:0] == OP_LOAD) & ~mem_ready;
   assign stall = raw_hazard | load_hazard;
   assign hold = out_valid & ~out_ready;
   assign in_ready = ~stall & ~hold & ~flush;
   assign accept = in_valid & in_ready;
   assign redirect = out_valid & out_ready & (out_inst[6:0] inside {OP_JAL, OP_JALR, OP_BRANCH});

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_inst <= NOP_INST;
         out_pc <= RESET_PC;
         out_payload <= '0;
         out_rd_addr <= '0;
         out_rd_we <= 1'b0;
      end else if (flush || (!hold && (redirect || !accept))) begin
         out_valid <= 1'b0;
         out_inst <= NOP_INST;
         out_rd_we <= 1'b0;
      end else if (!hold) begin
         out_valid <= 1'b1;
         out_inst <= in_inst;
         out_pc <= in_pc;
         out_payload <= in_payload;
         out_rd_addr <= in_rd_addr;
         out_rd_we <= in_rd_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) stall_count <= '0;
      else if (stall && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
   end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed scenarios plus randomized traffic checked cycle by cycle
// against a behavioural model of the execute stage register.
module tb_ex_stage_pipe;
   localparam int XLEN = 64;
   localparam int RA = 5;
   localparam int PW = 192;
   localparam int TD = 3;
   localparam int CW = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [XLEN-1:0] RPC = 64'h0000_0000_8000_0000;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_ADD = 7'b0110011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, in_rs1_used, in_rs2_used, in_rd_we, mem_ready, flush;
   logic out_valid, out_ready, out_rd_we, redirect, stall;
   logic [31:0] in_inst, out_inst;
   logic [XLEN-1:0] in_pc, out_pc;
   logic [PW-1:0] in_payload, out_payload;
   logic [RA-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr, out_rd_addr;
   logic [CW-1:0] stall_count;

   ex_stage_pipe #(.XLEN(XLEN), .REG_ADDR_W(RA), .PAYLOAD_W(PW), .TRACK_DEPTH(TD), .CNT_W(CW),
                   .NOP_INST(NOP), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
      .in_pc(in_pc), .in_payload(in_payload), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_rd_addr(in_rd_addr),
      .in_rd_we(in_rd_we), .mem_ready(mem_ready), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_payload(out_payload),
      .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .redirect(redirect), .stall(stall),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [6:0] ops [5] = '{OP_ADDI, OP_ADD, OP_LD, OP_BEQ, OP_JAL};

   // model: the instruction held at the output, and rd of older handed-off writers (0 = none), newest first
   logic m_v, m_we;
   logic [31:0] m_inst;
   logic [XLEN-1:0] m_pc;
   logic [PW-1:0] m_pay;
   logic [RA-1:0] m_rd;
   int m_cnt;
   int hist[$];

   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic is_cf(input logic [31:0] i);
      return i[6:0] inside {7'b1101111, 7'b1100111, 7'b1100011};
   endfunction

   task automatic model_reset();
      m_v = 1'b0;
      m_inst = NOP;
      m_pc = RPC;
      m_pay = '0;
      m_rd = '0;
      m_we = 1'b0;
      m_cnt = 0;
      hist = {};
      for (int k = 0; k < TD - 1; k++) hist.push_back(0);
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input int rd, input logic we,
                        input int rs1, input logic u1, input int rs2, input logic u2);
      in_valid = v;
      in_inst = $urandom;
      in_inst[6:0] = op;
      in_rd_addr = RA'(rd);
      in_rd_we = we;
      in_rs1_addr = RA'(rs1);
      in_rs1_used = u1;
      in_rs2_addr = RA'(rs2);
      in_rs2_used = u2;
      in_pc = {$urandom, $urandom};
      for (int i = 0; i < PW / 32; i++) in_payload[i*32 +: 32] = $urandom;
   endtask

   // one clock: compare DUT to model, then advance the model across the edge
   task automatic step(output logic es, output logic ea);
      logic raw, er, rdr;
      int w;
      #1;
      raw = 1'b0;
      if (in_valid) begin
         for (int k = -1; k < hist.size(); k++) begin
            w = (k < 0) ? ((m_v && m_we) ? int'(m_rd) : 0) : hist[k];
            if (w != 0 && ((in_rs1_used && w == int'(in_rs1_addr)) || (in_rs2_used && w == int'(in_rs2_addr)))) raw = 1'b1;
         end
      end
      es = raw || (in_valid && in_inst[6:0] == OP_LD && !mem_ready);
      er = !es && (!m_v || out_ready) && !flush;
      rdr = m_v && out_ready && is_cf(m_inst);
      ea = in_valid && er && !rdr;
      check("stall", PW'(stall), PW'(es));
      check("in_ready", PW'(in_ready), PW'(er));
      check("redirect", PW'(redirect), PW'(rdr));
      check("out_valid", PW'(out_valid), PW'(m_v));
      check("out_inst", PW'(out_inst), PW'(m_inst));
      check("out_pc", PW'(out_pc), PW'(m_pc));
      check("out_payload", out_payload, m_pay);
      check("out_rd_we", PW'(out_rd_we), PW'(m_we));
      if (m_v) check("out_rd_addr", PW'(out_rd_addr), PW'(m_rd));
      check("stall_count", PW'(stall_count), PW'(m_cnt));
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (es && m_cnt < 2**CW - 1) m_cnt++;
         if (flush) begin
            foreach (hist[k]) hist[k] = 0;
         end else begin
            hist.push_front((m_v && out_ready && m_we) ? int'(m_rd) : 0);
            void'(hist.pop_back());
         end
         if (flush) begin
            m_v = 1'b0; m_inst = NOP; m_we = 1'b0;
         end else if (m_v && !out_ready) begin
         end else if (rdr) begin
            m_v = 1'b0; m_inst = NOP; m_we = 1'b0;
         end else if (in_valid && er) begin
            m_v = 1'b1; m_inst = in_inst; m_pc = in_pc; m_pay = in_payload; m_rd = in_rd_addr; m_we = in_rd_we;
         end else begin
            m_v = 1'b0; m_inst = NOP; m_we = 1'b0;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      logic es, ea;
      rst = 1'b1;
      step(es, ea);
      rst = 1'b0;
   endtask

   initial begin
      logic es, ea;
      int n, g;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b1; mem_ready = 1'b1;
      drive(1'b1, OP_ADDI, 1, 1'b1, 0, 1'b1, 0, 1'b0);
      @(posedge clk);
      #1;
      model_reset();
      step(es, ea);
      step(es, ea);
      check("rst_valid", PW'(out_valid), PW'(1'b0));
      check("rst_inst", PW'(out_inst), PW'(32'h13));
      check("rst_pc", PW'(out_pc), PW'(RPC));
      check("rst_cnt", PW'(stall_count), PW'(0));
      rst = 1'b0;
      for (int r = 1; r <= 4; r++) begin
         drive(1'b1, OP_ADDI, r, 1'b1, 0, 1'b1, 0, 1'b0);
         step(es, ea);
         check("b2b_valid", PW'(out_valid), PW'(1'b1));
         check("b2b_rd", PW'(out_rd_addr), PW'(r));
      end
      do_reset();
      drive(1'b1, OP_ADDI, 5, 1'b1, 0, 1'b1, 0, 1'b0);
      step(es, ea);
      drive(1'b1, OP_ADD, 6, 1'b1, 5, 1'b1, 5, 1'b1);
      n = 0;
      g = 0;
      do begin
         step(es, ea);
         g++;
         if (es) begin
            n++;
            check("raw_bubble", PW'(out_inst), PW'(NOP));
         end
      end while (!ea && g < 10);
      check("raw_stalls", PW'(n), PW'(3));
      check("raw_cnt", PW'(stall_count), PW'(3));
      check("raw_issue", PW'(out_rd_addr), PW'(6));
      drive(1'b1, OP_ADDI, 0, 1'b1, 0, 1'b1, 0, 1'b0);
      step(es, ea);
      drive(1'b1, OP_ADD, 6, 1'b1, 0, 1'b1, 0, 1'b1);
      step(es, ea);
      check("x0_issue_valid", PW'(out_valid), PW'(1'b1));
      check("x0_issue_rd", PW'(out_rd_addr), PW'(6));
      drive(1'b1, OP_LD, 9, 1'b1, 1, 1'b1, 0, 1'b0);
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(es, ea);
         check("ld_stall", PW'(stall), PW'(1'b1));
         check("ld_ready", PW'(in_ready), PW'(1'b0));
      end
      mem_ready = 1'b1;
      step(es, ea);
      check("ld_issue_valid", PW'(out_valid), PW'(1'b1));
      check("ld_issue_rd", PW'(out_rd_addr), PW'(9));
      drive(1'b1, OP_BEQ, 0, 1'b0, 1, 1'b0, 2, 1'b0);
      step(es, ea);
      drive(1'b1, OP_ADDI, 10, 1'b1, 0, 1'b1, 0, 1'b0);
      check("br_redirect", PW'(redirect), PW'(1'b1));
      step(es, ea);
      check("br_squash", PW'(out_valid), PW'(1'b0));
      check("br_redirect_off", PW'(redirect), PW'(1'b0));
      drive(1'b1, OP_ADDI, 7, 1'b1, 0, 1'b1, 0, 1'b0);
      step(es, ea);
      out_ready = 1'b0;
      drive(1'b1, OP_ADD, 8, 1'b1, 7, 1'b1, 7, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(es, ea);
         check("bp_ready", PW'(in_ready), PW'(1'b0));
         check("bp_hold", PW'(out_rd_addr), PW'(7));
         check("bp_valid", PW'(out_valid), PW'(1'b1));
      end
      flush = 1'b1;
      step(es, ea);
      check("fl_valid", PW'(out_valid), PW'(1'b0));
      flush = 1'b0;
      out_ready = 1'b1;
      check("fl_nostall", PW'(stall), PW'(1'b0));
      step(es, ea);
      check("fl_issue", PW'(out_rd_addr), PW'(8));
      do_reset();
      drive(1'b1, OP_LD, 3, 1'b1, 0, 1'b0, 0, 1'b0);
      mem_ready = 1'b0;
      repeat (2**CW + 5) step(es, ea);
      check("sat_cnt", PW'(stall_count), PW'({CW{1'b1}}));
      mem_ready = 1'b1;
      repeat (600) begin
         rst = ($urandom_range(63) == 0);
         flush = ($urandom_range(15) == 0);
         out_ready = ($urandom_range(3) != 0);
         mem_ready = ($urandom_range(3) != 0);
         drive($urandom_range(3) != 0, ops[$urandom_range(4)], int'($urandom_range(7)), 1'($urandom_range(1)),
               int'($urandom_range(7)), 1'($urandom_range(1)), int'($urandom_range(7)), 1'($urandom_range(1)));
         step(es, ea);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
